multi_operand_accum: RTL and testbench

//  Sequential multi-operand adder: sums a group of NUM_OPS unsigned WIDTH-bit operands plus a carry-in.

---
 rtl/multi_operand_accum_if.sv | 46 ++++
 rtl/multi_operand_accum.sv | 155 +++++++++++++++
 tb/tb_multi_operand_accum.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/multi_operand_accum_if.sv
// ============================================================================
// Module   : multi_operand_accum_if
// Brief    : Operand-in / sum-out handshake bundle for multi_operand_accum.
//            The ov signal exists only when MOA_OVF_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface multi_operand_accum_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 4
);
  localparam int SW = WIDTH + $clog2(NUM_OPS);
  localparam int CW = $clog2(NUM_OPS) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ci;
  logic             out_valid;
  logic             out_ready;
  logic [SW-1:0]    out_sum;
  logic [CW-1:0]    out_cnt;
`ifdef MOA_OVF_EN
  logic             ov;
`endif

  // master: operand source plus result consumer; slave: the accumulator
  modport master (
    output in_valid, in_data, ci, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt
`ifdef MOA_OVF_EN
    , input ov
`endif
  );

  modport slave (
    input  in_valid, in_data, ci, out_ready,
    output in_ready, out_valid, out_sum, out_cnt
`ifdef MOA_OVF_EN
    , output ov
`endif
  );
endinterface : multi_operand_accum_if

`default_nettype wire

// File: rtl/multi_operand_accum.sv
// ============================================================================
// Module   : multi_operand_accum
// Brief    : Sequential adder summing NUM_OPS unsigned operands plus carry-in,
//            one operand per cycle, one widened sum per group.
//            Optional overflow flag ov is enabled by defining MOA_OVF_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multi_operand_accum #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  multi_operand_accum_if.slave   bus
);

  localparam int SW = WIDTH + $clog2(NUM_OPS);
  localparam int CW = $clog2(NUM_OPS) + 1;

  localparam logic [CW-1:0] c_LAST_IDX = CW'(NUM_OPS - 1);
  localparam logic [CW-1:0] c_CNT_ZERO = '0;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [SW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_out_sum;
  logic          r_out_valid;

  logic          w_in_ready;
  logic          w_accept;
  logic          w_last;
  logic          w_out_fire;
  logic [SW-1:0] w_data_ext;
  logic [SW-1:0] w_acc_next;

`ifdef MOA_OVF_EN
  logic          r_ov;
  logic          w_ov_next;
`endif

  // --------------------------------------------------------------------------
  // Datapath helpers
  // --------------------------------------------------------------------------
  always_comb begin
    w_data_ext = {{(SW-WIDTH){1'b0}}, bus.in_data};
    // The first operand of a group restarts the sum and folds in the carry-in
    if (r_cnt == c_CNT_ZERO) begin
      w_acc_next = w_data_ext + {{(SW-1){1'b0}}, bus.ci};
    end else begin
      w_acc_next = r_acc + w_data_ext;
    end
  end

`ifdef MOA_OVF_EN
  assign w_ov_next = |w_acc_next[SW-1:WIDTH];
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    w_out_fire   = 1'b0;

    case (r_state)
      ST_ACC: begin
        w_in_ready = 1'b1;
        w_accept   = bus.in_valid;
        w_last     = bus.in_valid && (r_cnt == c_LAST_IDX);
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_out_fire = r_out_valid && bus.out_ready;
        if (w_out_fire) begin
          w_state_next = ST_ACC;
        end
      end
      default: begin
        w_state_next = ST_ACC;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Accumulator, operand counter and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_acc_next;
        r_cnt <= w_last ? c_CNT_ZERO : (r_cnt + 1'b1);
      end
      // Result register only moves on the edge that raises out_valid
      if (w_last) begin
        r_out_sum   <= w_acc_next;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef MOA_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ov <= 1'b0;
    end else if (w_last) begin
      r_ov <= w_ov_next;
    end
  end

  assign bus.ov = r_ov;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_cnt   = r_cnt;

endmodule : multi_operand_accum

`default_nettype wire

// File: tb/tb_multi_operand_accum.sv
// ============================================================================
// Module   : tb_multi_operand_accum
// Brief    : Directed-vector scoreboard bench for multi_operand_accum
//            (WIDTH=8, NUM_OPS=4); ov is checked when MOA_OVF_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multi_operand_accum;

  localparam int WIDTH   = 8;
  localparam int NUM_OPS = 4;
  localparam int SW      = WIDTH + $clog2(NUM_OPS);

  typedef struct {
    int    sum;
    int    ov;
    string name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  multi_operand_accum_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) bus ();

  multi_operand_accum #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic int get_ov();
`ifdef MOA_OVF_EN
    return int'(bus.ov);
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a result transfers on the next rising edge whenever both sides are high
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_result", int'(bus.out_sum), -1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, "_sum"}, int'(bus.out_sum), e.sum);
`ifdef MOA_OVF_EN
        chk({e.name, "_ov"}, get_ov(), e.ov);
`endif
      end
    end
  end

  // Drive one operand from posedge+1; returns at posedge+1 after it is accepted
  task automatic send_op(input int d, input bit c);
    bit taken;
    int n;
    taken        = 1'b0;
    n            = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(d);
    bus.ci       = c;
    while (!taken && n < 50) begin
      @(negedge clk);
      taken = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!taken) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_sum(input int s, input string name);
    exp_t e;
    e.sum  = s;
    e.ov   = (s > 255) ? 1 : 0;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int ops3[4];
    ops3 = '{125, 110, 63, 211};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ci        = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  int'(bus.in_ready),  1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sum",   int'(bus.out_sum),   0);
    chk("rst_out_cnt",   int'(bus.out_cnt),   0);
    chk("rst_ov",        get_ov(),            0);
    idle(3);
    rst = 1'b0;
    idle(1);

    // 1: back-to-back group, single-cycle out_valid one edge after the 4th accept
    expect_sum(101, "t1");
    send_op(5, 1'b1);
    send_op(10, 1'b0);
    send_op(37, 1'b0);
    send_op(48, 1'b0);
    @(negedge clk);
    chk("t1_valid_rise", int'(bus.out_valid), 1);
    chk("t1_done_cnt",   int'(bus.out_cnt),   0);
    chk("t1_done_ready", int'(bus.in_ready),  0);
    @(negedge clk);
    chk("t1_valid_fall", int'(bus.out_valid), 0);
    chk("t1_hold_sum",   int'(bus.out_sum),   101);
    @(posedge clk);
    #1;

    // 2: maximum operands, no wrap in the widened sum
    expect_sum(1021, "t2");
    repeat (4) send_op(255, 1'b1);
    idle(2);

    // 3: gaps between operands, counter holds across stalls
    expect_sum(509, "t3");
    @(negedge clk);
    chk("t3_cnt0", int'(bus.out_cnt), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      send_op(ops3[i], 1'b0);
      if (i < 3) begin
        idle(3);
        @(negedge clk);
        chk($sformatf("t3_cnt%0d", i + 1), int'(bus.out_cnt), i + 1);
        @(posedge clk);
        #1;
      end
    end
    idle(2);

    // 4: consumer stall with next-group operand presented throughout
    bus.out_ready = 1'b0;
    expect_sum(100, "t4a");
    send_op(10, 1'b0);
    send_op(20, 1'b0);
    send_op(30, 1'b0);
    send_op(40, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd1;
    bus.ci       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", int'(bus.out_valid), 1);
      chk("t4_stall_ready", int'(bus.in_ready),  0);
      chk("t4_stall_sum",   int'(bus.out_sum),   100);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    idle(1);
    @(negedge clk);
    chk("t4_after_cnt", int'(bus.out_cnt), 0);
    @(posedge clk);
    #1;
    expect_sum(10, "t4b");
    send_op(1, 1'b0);
    send_op(2, 1'b0);
    send_op(3, 1'b0);
    send_op(4, 1'b0);
    idle(2);

    // 5: asynchronous reset mid-group discards the partial sum
    send_op(7, 1'b1);
    send_op(9, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_cnt",   int'(bus.out_cnt),   0);
    chk("t5_rst_ready", int'(bus.in_ready),  1);
    chk("t5_rst_valid", int'(bus.out_valid), 0);
    chk("t5_rst_sum",   int'(bus.out_sum),   0);
    idle(2);
    rst = 1'b0;
    idle(1);
    expect_sum(394, "t5");
    send_op(100, 1'b1);
    send_op(200, 1'b0);
    send_op(3, 1'b0);
    send_op(90, 1'b0);
    idle(2);

    // 6: carry-in only counts with the first operand
    expect_sum(0, "t6");
    send_op(0, 1'b0);
    send_op(0, 1'b1);
    send_op(0, 1'b1);
    send_op(0, 1'b1);
    idle(4);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1);
  end

endmodule : tb_multi_operand_accum

`default_nettype wire
